// File: rtl/mod_segment_scheduler.sv
// Two-segment modulation scheduler: latches segment-change requests, waits for the
// selected trigger, then drives the active segment and counts loops against its repeat limit.
module mod_segment_scheduler #(
  parameter int                   REP_WIDTH    = 16,
  parameter int                   SYNC_STAGES  = 2,
  parameter logic [REP_WIDTH-1:0] REP_INFINITE = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 update,
  input  logic                 req_rd_segment,
  input  logic [7:0]           transition_mode,
  input  logic [63:0]          transition_value,
  input  logic [REP_WIDTH-1:0] rep0,
  input  logic [REP_WIDTH-1:0] rep1,
  input  logic [63:0]          sys_time,
  input  logic                 loop_end,
  input  logic [3:0]           gpio_in,
  output logic                 segment,
  output logic                 stop,
  output logic                 swap,
  output logic [REP_WIDTH-1:0] loop_cnt,
  output logic                 mode_err
);

  // state      | meaning
  // ST_RUN     | playing segment, counting loops
  // ST_WAIT    | request pending, current segment keeps playing
  // ST_HALT    | repeat limit reached, stop held high

  localparam logic [7:0] MODE_SYNC_IDX  = 8'h00;
  localparam logic [7:0] MODE_SYS_TIME  = 8'h01;
  localparam logic [7:0] MODE_GPIO      = 8'h02;
  localparam logic [7:0] MODE_EXT       = 8'hF0;
  localparam logic [7:0] MODE_IMMEDIATE = 8'hFF;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;

  state_t                       state_q, state_d;
  logic                         pend_seg_q;
  logic [7:0]                   pend_mode_q;
  logic [63:0]                  pend_value_q;
  logic [REP_WIDTH-1:0]         rep0_q, rep1_q, rep_lim_q;
  logic                         ext_alt_q;
  logic [SYNC_STAGES-1:0][3:0]  gpio_sync_q;
  logic [3:0]                   gpio_last_q;
  logic [3:0]                   gpio_rise;

  logic                         mode_known, req_ok, req_bad, req_now;
  logic                         trig, limit_hit, count_en;
  logic                         take_swap, swap_seg, swap_ext, go_halt;
  logic [REP_WIDTH-1:0]         swap_rep;
  logic                         seg_d, stop_d, swap_d, err_d, ext_alt_d;
  logic [REP_WIDTH-1:0]         cnt_d, rep_lim_d;

  always_comb begin
    mode_known = 1'b0;
    case (transition_mode)
      MODE_SYNC_IDX, MODE_SYS_TIME, MODE_GPIO, MODE_EXT, MODE_IMMEDIATE: mode_known = 1'b1;
      default: mode_known = 1'b0;
    endcase
  end

  assign req_ok  = update & mode_known;
  assign req_bad = update & ~mode_known;
  // While stopped the reader emits no loop_end, so loop-synchronous requests fire at once.
  assign req_now = (transition_mode == MODE_IMMEDIATE) ||
                   (stop && ((transition_mode == MODE_SYNC_IDX) || (transition_mode == MODE_EXT)));

  assign gpio_rise = gpio_sync_q[SYNC_STAGES-1] & ~gpio_last_q;

  always_comb begin
    trig = 1'b0;
    case (pend_mode_q)
      MODE_SYNC_IDX, MODE_EXT: trig = loop_end;
      MODE_SYS_TIME:           trig = (sys_time >= pend_value_q);
      MODE_GPIO:               trig = gpio_rise[pend_value_q[1:0]];
      default:                 trig = 1'b0;
    endcase
  end

  assign limit_hit = (state_q == ST_RUN) && loop_end && (rep_lim_q != REP_INFINITE) &&
                     (loop_cnt == rep_lim_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    take_swap = 1'b0;
    go_halt   = 1'b0;
    swap_seg  = pend_seg_q;
    swap_rep  = pend_seg_q ? rep1_q : rep0_q;
    swap_ext  = (pend_mode_q == MODE_EXT);
    if (req_ok) begin
      if (req_now) begin
        take_swap = 1'b1;
        swap_seg  = req_rd_segment;
        swap_rep  = req_rd_segment ? rep1 : rep0;
        swap_ext  = (transition_mode == MODE_EXT);
      end else begin
        state_d = ST_WAIT;
      end
    end else if (!update) begin
      case (state_q)
        ST_WAIT: if (trig) take_swap = 1'b1;
        ST_RUN: begin
          if (limit_hit) begin
            if (ext_alt_q) begin
              take_swap = 1'b1;
              swap_seg  = ~segment;
              swap_rep  = segment ? rep0_q : rep1_q;
              swap_ext  = 1'b1;
            end else begin
              go_halt = 1'b1;
              state_d = ST_HALT;
            end
          end
        end
        default: ;
      endcase
    end
    if (take_swap) state_d = ST_RUN;
  end

  always_comb begin
    count_en  = (state_q == ST_RUN) && loop_end && !update && !take_swap;
    seg_d     = segment;
    stop_d    = stop;
    swap_d    = take_swap;
    err_d     = req_bad;
    cnt_d     = loop_cnt;
    rep_lim_d = rep_lim_q;
    ext_alt_d = req_ok ? 1'b0 : ext_alt_q;
    if (take_swap) begin
      seg_d     = swap_seg;
      stop_d    = 1'b0;
      cnt_d     = '0;
      rep_lim_d = swap_rep;
      ext_alt_d = swap_ext;
    end else begin
      if (go_halt) stop_d = 1'b1;
      if (count_en && (loop_cnt != '1)) cnt_d = loop_cnt + REP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segment      <= 1'b0;
      stop         <= 1'b0;
      swap         <= 1'b0;
      loop_cnt     <= '0;
      mode_err     <= 1'b0;
      rep_lim_q    <= REP_INFINITE;
      ext_alt_q    <= 1'b0;
      pend_seg_q   <= 1'b0;
      pend_mode_q  <= MODE_IMMEDIATE;
      pend_value_q <= '0;
      rep0_q       <= REP_INFINITE;
      rep1_q       <= REP_INFINITE;
    end else begin
      segment   <= seg_d;
      stop      <= stop_d;
      swap      <= swap_d;
      loop_cnt  <= cnt_d;
      mode_err  <= err_d;
      rep_lim_q <= rep_lim_d;
      ext_alt_q <= ext_alt_d;
      if (req_ok) begin
        pend_seg_q   <= req_rd_segment;
        pend_mode_q  <= transition_mode;
        pend_value_q <= transition_value;
        rep0_q       <= rep0;
        rep1_q       <= rep1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_sync_q <= '0;
      gpio_last_q <= '0;
    end else begin
      gpio_sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) gpio_sync_q[i] <= gpio_sync_q[i-1];
      gpio_last_q <= gpio_sync_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: tb/tb_mod_segment_scheduler.sv
// Directed plus randomized bench for mod_segment_scheduler against a behavioural model
// that tracks the request/loop/halt rules and keeps a raw history of gpio_in samples.
module tb_mod_segment_scheduler;
  localparam int          SYNC = 2;
  localparam int unsigned INF  = 32'h0000_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        update = 1'b0;
  logic        req_rd_segment = 1'b0;
  logic [7:0]  transition_mode = 8'h00;
  logic [63:0] transition_value = '0;
  logic [15:0] rep0 = '0;
  logic [15:0] rep1 = '0;
  logic [63:0] sys_time = '0;
  logic        loop_end = 1'b0;
  logic [3:0]  gpio_in = '0;
  logic        segment, stop, swap, mode_err;
  logic [15:0] loop_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // behavioural model
  bit          m_seg, m_stop, m_swap, m_err, m_pending, m_halted, m_alt;
  int unsigned m_cnt, m_rep;
  bit          p_seg;
  logic [7:0]  p_mode;
  logic [63:0] p_val;
  int unsigned p_rep0, p_rep1;
  logic [3:0]  g_hist [0:SYNC+1];
  bit          seg_before;

  mod_segment_scheduler #(.REP_WIDTH(16), .SYNC_STAGES(SYNC), .REP_INFINITE(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .update(update), .req_rd_segment(req_rd_segment),
    .transition_mode(transition_mode), .transition_value(transition_value),
    .rep0(rep0), .rep1(rep1), .sys_time(sys_time), .loop_end(loop_end), .gpio_in(gpio_in),
    .segment(segment), .stop(stop), .swap(swap), .loop_cnt(loop_cnt), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_seg = 0; m_stop = 0; m_swap = 0; m_err = 0; m_pending = 0; m_halted = 0; m_alt = 0;
    m_cnt = 0; m_rep = INF; p_seg = 0; p_mode = 8'hFF; p_val = '0; p_rep0 = INF; p_rep1 = INF;
    for (int i = 0; i <= SYNC + 1; i++) g_hist[i] = '0;
  endtask

  task automatic model_swap(input bit s, input int unsigned r, input bit alt);
    m_seg = s; m_swap = 1; m_stop = 0; m_cnt = 0; m_rep = r; m_alt = alt;
    m_pending = 0; m_halted = 0;
  endtask

  function automatic bit known_mode(input logic [7:0] md);
    return md == 8'h00 || md == 8'h01 || md == 8'h02 || md == 8'hF0 || md == 8'hFF;
  endfunction

  task automatic model_step();
    bit          trig;
    int          b;
    int unsigned done;
    for (int i = SYNC + 1; i > 0; i--) g_hist[i] = g_hist[i-1];
    g_hist[0] = gpio_in;
    m_swap = 0; m_err = 0;
    trig = 0;
    if (m_pending) begin
      if (p_mode == 8'h00 || p_mode == 8'hF0) trig = loop_end;
      else if (p_mode == 8'h01) trig = (sys_time >= p_val);
      else if (p_mode == 8'h02) begin
        b = int'(p_val[1:0]);
        trig = g_hist[SYNC][b] && !g_hist[SYNC+1][b];
      end
    end
    if (update && !known_mode(transition_mode)) begin
      m_err = 1;
    end else if (update) begin
      p_seg = req_rd_segment; p_mode = transition_mode; p_val = transition_value;
      p_rep0 = rep0; p_rep1 = rep1; m_alt = 0;
      if (transition_mode == 8'hFF ||
          (m_stop && (transition_mode == 8'h00 || transition_mode == 8'hF0)))
        model_swap(req_rd_segment, req_rd_segment ? rep1 : rep0, transition_mode == 8'hF0);
      else begin
        m_pending = 1; m_halted = 0;
      end
    end else if (m_pending) begin
      if (trig) model_swap(p_seg, p_seg ? p_rep1 : p_rep0, p_mode == 8'hF0);
    end else if (!m_halted && loop_end) begin
      done = m_cnt + 1;
      if (m_rep != INF && done > m_rep) begin
        if (m_alt) model_swap(!m_seg, m_seg ? p_rep0 : p_rep1, 1);
        else begin
          m_halted = 1; m_stop = 1; m_cnt = done;
        end
      end else if (m_cnt < INF) m_cnt = done;
    end
  endtask

  task automatic check_all();
    chk("segment", segment, m_seg);
    chk("stop", stop, m_stop);
    chk("swap", swap, m_swap);
    chk("loop_cnt", loop_cnt, m_cnt);
    chk("mode_err", mode_err, m_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    update = 0;
    loop_end = 0;
    sys_time = sys_time + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_loop();
    loop_end = 1;
    cycle();
  endtask

  task automatic drive_update(input bit s, input logic [7:0] md, input logic [63:0] val,
                              input int unsigned r0, input int unsigned r1);
    update = 1; req_rd_segment = s; transition_mode = md; transition_value = val;
    rep0 = r0[15:0]; rep1 = r1[15:0];
    cycle();
  endtask

  initial begin
    #2 rst_n = 0;
    model_reset();
    #1 check_all();
    @(negedge clk) rst_n = 1;

    // immediate swap to seg1, three loops with rep 2 then halt
    drive_update(1, 8'hFF, 64'd0, $urandom_range(0, 5), 2);
    chk("t1_seg", segment, 1);
    chk("t1_swap", swap, 1);
    for (int k = 0; k < 3; k++) begin
      idle($urandom_range(0, 3));
      pulse_loop();
    end
    chk("t1_stop_now", stop, 1);
    idle(3);
    chk("t1_stop", stop, 1);
    chk("t1_cnt", loop_cnt, 3);

    // loop-synchronous request with infinite repeat
    drive_update(0, 8'hFF, 64'd0, INF, INF);
    drive_update(1, 8'h00, 64'd0, INF, INF);
    idle($urandom_range(5, 20));
    chk("t2_wait_seg", segment, 0);
    pulse_loop();
    chk("t2_seg", segment, 1);
    for (int k = 0; k < 20; k++) begin
      idle($urandom_range(0, 2));
      pulse_loop();
    end
    chk("t2_stop", stop, 0);
    chk("t2_cnt", loop_cnt, 20);

    // system-time threshold
    sys_time = 64'd900;
    drive_update(0, 8'h01, 64'd1000, $urandom_range(0, 9), $urandom_range(0, 9));
    for (int i = 0; i < 200 && sys_time != 64'd1000; i++) cycle();
    chk("t3_before", segment, 1);
    cycle();
    chk("t3_seg", segment, 0);
    chk("t3_swap", swap, 1);
    idle(3);

    // gpio trigger on bit 2; bit 1 ignored
    drive_update(1, 8'h02, 64'd2, INF, INF);
    gpio_in = 4'b0010; cycle(); gpio_in = 4'b0000;
    idle(6);
    chk("t4_ignore", segment, 0);
    gpio_in = 4'b0100; cycle(); gpio_in = 4'b0000;
    for (int k = 1; k < SYNC; k++) begin
      cycle();
      chk("t4_early", swap, 0);
    end
    cycle();
    chk("t4_swap", swap, 1);
    chk("t4_seg", segment, 1);
    idle(2);

    // ext alternation rep0=0, rep1=1
    drive_update(0, 8'hFF, 64'd0, INF, INF);
    drive_update(1, 8'hF0, 64'd0, 0, 1);
    idle(2);
    for (int k = 0; k < 12; k++) begin
      idle($urandom_range(0, 3));
      pulse_loop();
    end
    chk("t5_stop", stop, 0);

    // unknown mode
    seg_before = m_seg;
    drive_update(!m_seg, 8'h55, 64'd0, 0, 0);
    chk("t6_err", mode_err, 1);
    chk("t6_seg", segment, seg_before);
    cycle();
    chk("t6_err_off", mode_err, 0);

    // update coincident with loop_end while a loop-synchronous request is pending
    drive_update(!m_seg, 8'h00, 64'd0, INF, INF);
    update = 1; req_rd_segment = !m_seg; transition_mode = 8'h01;
    transition_value = 64'hFFFF_FFFF_FFFF_FFFF; loop_end = 1;
    cycle();
    chk("t7_noswap", swap, 0);
    pulse_loop();
    chk("t7_noswap2", swap, 0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        update = 1;
        req_rd_segment = $urandom_range(0, 1);
        case ($urandom_range(0, 6))
          0: transition_mode = 8'h00;
          1: transition_mode = 8'h01;
          2: transition_mode = 8'h02;
          3: transition_mode = 8'hF0;
          4: transition_mode = 8'hFF;
          5: transition_mode = 8'h55;
          default: transition_mode = 8'($urandom);
        endcase
        transition_value = (transition_mode == 8'h01) ? sys_time + 64'($urandom_range(0, 40))
                                                     : 64'($urandom);
        rep0 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
        rep1 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
      end
      loop_end = ($urandom_range(0, 3) == 0);
      gpio_in  = 4'($urandom);
      cycle();
    end
    gpio_in = '0;

    // asynchronous reset in the middle of a run
    drive_update(1, 8'hFF, 64'd0, INF, INF);
    pulse_loop();
    pulse_loop();
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    chk("t8_cnt", loop_cnt, 0);
    @(negedge clk) rst_n = 1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
